// File: rtl/cpu_pkg.sv
// Shared types and constants for the RSA CPU execute stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_MUL = 3'b100,
        ALU_MOD = 3'b101,
        ALU_MOV = 3'b110,
        ALU_RSV = 3'b111
    } alu_op_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic [1:0] {
        FWD_RD  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_ALT = 2'b11
    } fwd_sel_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ex_state_t;

    // ARM condition field evaluated against an {N,Z,C,V} flag vector; 1111 never executes.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = !z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = !c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = !n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = !v;
            COND_HI: cond_holds = c && !z;
            COND_LS: cond_holds = !c || z;
            COND_GE: cond_holds = (n == v);
            COND_LT: cond_holds = (n != v);
            COND_GT: cond_holds = !z && (n == v);
            COND_LE: cond_holds = z || (n != v);
            COND_AL: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative multiply / unsigned modulo unit: one shift-add or restoring-subtract step per cycle.
module iter_muldiv
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_mod,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    ex_state_t        state, state_next;
    logic [CW-1:0]    count;
    logic             mod_mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] mul_sum;
    logic             div_by_zero;

    assign div_by_zero = is_mod && (b == '0);
    assign rem_shift   = {acc, op_a[WIDTH-1]};
    assign mul_sum     = acc + op_a;
    assign result      = acc;

    // Next-state and busy/done decode; a zero divisor skips straight to DONE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy       = 1'b1;
                    state_next = div_by_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter and operand registers; operands are captured once at start.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            mod_mode <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mod_mode <= is_mod;
                        op_a     <= a;
                        op_b     <= b;
                        count    <= CW'(WIDTH - 1);
                        acc      <= div_by_zero ? a : '0;
                    end
                end
                ST_RUN: begin
                    count <= count - 1'b1;
                    op_a  <= op_a << 1;
                    if (mod_mode) begin
                        if (rem_shift >= {1'b0, op_b}) begin
                            acc <= WIDTH'(rem_shift - {1'b0, op_b});
                        end else begin
                            acc <= rem_shift[WIDTH-1:0];
                        end
                    end else begin
                        if (op_b[0]) begin
                            acc <= mul_sum;
                        end
                        op_b <= op_b >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarding, condition check, NZCV flags, single-cycle ALU and the iterative MUL/MOD unit.
module execute_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemtoRegE,
    input  logic             BranchE,
    input  logic             ALUSrcE,
    input  logic             FlagWriteE,
    input  logic [2:0]       ALUControlE,
    input  logic [3:0]       condE,
    input  logic [WIDTH-1:0] rd1E,
    input  logic [WIDTH-1:0] rd2E,
    input  logic [WIDTH-1:0] ExtImmE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic             PCSrcOutE,
    output logic             RegWriteOutE,
    output logic             MemWriteOutE,
    output logic             MemtoRegOutE,
    output logic             BranchTakenE,
    output logic [3:0]       FlagsOut,
    output logic             BusyE
);

    alu_op_t          op;
    logic [WIDTH-1:0] src_a, src_b_fwd, src_b;
    logic [WIDTH-1:0] alu_result, md_result;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic [3:0]       flags, flags_next;
    logic             cond_ex, flag_we, is_multi, md_busy, md_done;

    assign op = alu_op_t'(ALUControlE);

    // Operand forwarding; the unused select code falls back to the register value.
    always_comb begin
        case (fwd_sel_t'(ForwardAE))
            FWD_MEM: src_a = ALUResultM;
            FWD_WB:  src_a = ResultW;
            default: src_a = rd1E;
        endcase
        case (fwd_sel_t'(ForwardBE))
            FWD_MEM: src_b_fwd = ALUResultM;
            FWD_WB:  src_b_fwd = ResultW;
            default: src_b_fwd = rd2E;
        endcase
    end

    assign src_b      = ALUSrcE ? ExtImmE : src_b_fwd;
    assign WriteDataE = src_b_fwd;
    assign cond_ex    = cond_holds(condE, flags);
    assign is_multi   = (op == ALU_MUL) || (op == ALU_MOD);

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (is_multi && cond_ex),
        .is_mod (op == ALU_MOD),
        .a      (src_a),
        .b      (src_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Single-cycle ALU and candidate flags; logical ops and MUL/MOD keep C and V.
    always_comb begin
        add_sum    = {1'b0, src_a} + {1'b0, src_b};
        sub_diff   = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_result = '0;
        flags_next = flags;
        case (op)
            ALU_ADD: begin
                alu_result         = add_sum[WIDTH-1:0];
                flags_next[FLAG_C] = add_sum[WIDTH];
                flags_next[FLAG_V] = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_result         = sub_diff[WIDTH-1:0];
                flags_next[FLAG_C] = sub_diff[WIDTH];
                flags_next[FLAG_V] = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                                     (sub_diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: alu_result = src_a & src_b;
            ALU_ORR: alu_result = src_a | src_b;
            ALU_MOV: alu_result = src_b;
            ALU_MUL, ALU_MOD: alu_result = md_done ? md_result : '0;
            default: alu_result = '0;
        endcase
        flags_next[FLAG_N] = alu_result[WIDTH-1];
        flags_next[FLAG_Z] = (alu_result == '0);
    end

    assign flag_we = FlagWriteE && cond_ex && !md_busy && (op != ALU_RSV);

    // NZCV register, written only by executed, non-stalled flag-setting instructions.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (flag_we) begin
            flags <= flags_next;
        end
    end

    assign ALUResultE   = alu_result;
    assign FlagsOut     = flags;
    assign BusyE        = md_busy;
    assign PCSrcOutE    = PCSrcE && cond_ex && !md_busy;
    assign RegWriteOutE = RegWriteE && cond_ex && !md_busy;
    assign MemWriteOutE = MemWriteE && cond_ex && !md_busy;
    assign MemtoRegOutE = MemtoRegE;
    assign BranchTakenE = BranchE && cond_ex;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized ops against a reference model.
module tb_execute_stage;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, FlagWriteE;
    logic [2:0]        ALUControlE;
    logic [3:0]        condE;
    logic [WIDTH-1:0]  rd1E, rd2E, ExtImmE, ALUResultM, ResultW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [WIDTH-1:0]  ALUResultE, WriteDataE;
    logic              PCSrcOutE, RegWriteOutE, MemWriteOutE, MemtoRegOutE, BranchTakenE, BusyE;
    logic [3:0]        FlagsOut;

    int                checks = 0;
    int                errors = 0;
    logic [3:0]        refFlags = 4'b0000;

    execute_stage #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .MemtoRegE    (MemtoRegE),
        .BranchE      (BranchE),
        .ALUSrcE      (ALUSrcE),
        .FlagWriteE   (FlagWriteE),
        .ALUControlE  (ALUControlE),
        .condE        (condE),
        .rd1E         (rd1E),
        .rd2E         (rd2E),
        .ExtImmE      (ExtImmE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .ALUResultM   (ALUResultM),
        .ResultW      (ResultW),
        .ALUResultE   (ALUResultE),
        .WriteDataE   (WriteDataE),
        .PCSrcOutE    (PCSrcOutE),
        .RegWriteOutE (RegWriteOutE),
        .MemWriteOutE (MemWriteOutE),
        .MemtoRegOutE (MemtoRegOutE),
        .BranchTakenE (BranchTakenE),
        .FlagsOut     (FlagsOut),
        .BusyE        (BusyE)
    );

    // Free-running clock; the DUT updates on the falling edge.
    always #5 clk = ~clk;

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pickSrc(input logic [1:0] sel, input logic [31:0] rd,
                                            input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'b10) return mem;
        if (sel == 2'b01) return wb;
        return rd;
    endfunction

    // Reference: returns {new NZCV, result} using plain arithmetic on wide integers.
    function automatic logic [35:0] refExec(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] f);
        longint    sr;
        logic [31:0] r;
        logic      c, v;
        c = f[1];
        v = f[0];
        r = 32'h0;
        case (op)
            3'd0: begin
                r  = a + b;
                c  = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
                sr = longint'($signed(a)) + longint'($signed(b));
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                r  = a - b;
                c  = (a >= b);
                sr = longint'($signed(a)) - longint'($signed(b));
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a * b;
            3'd5: r = (b == 32'h0) ? a : (a % b);
            3'd6: r = b;
            default: return {f, 32'h0};
        endcase
        return {r[31], (r == 32'h0), c, v, r};
    endfunction

    task automatic setIdEx(input logic [2:0] op, input logic [3:0] cond, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic useImm,
                           input logic fw, input logic [1:0] fa, input logic [1:0] fb);
        ALUControlE = op;
        condE       = cond;
        rd1E        = a;
        rd2E        = b;
        ExtImmE     = imm;
        ALUSrcE     = useImm;
        FlagWriteE  = fw;
        ForwardAE   = fa;
        ForwardBE   = fb;
        PCSrcE      = 1'b1;
        RegWriteE   = 1'b1;
        MemWriteE   = 1'b1;
        MemtoRegE   = 1'b1;
        BranchE     = 1'b1;
    endtask

    // Runs the instruction currently on the ID/EX inputs to completion and checks it; call at a rising edge.
    task automatic applyStimulus();
        logic        cond, multi, expBusy;
        logic [31:0] srcA, srcBf, srcB;
        logic [35:0] expv;
        int          cycles;
        #1;
        cond    = condHolds(condE, refFlags);
        srcA    = pickSrc(ForwardAE, rd1E, ALUResultM, ResultW);
        srcBf   = pickSrc(ForwardBE, rd2E, ALUResultM, ResultW);
        srcB    = ALUSrcE ? ExtImmE : srcBf;
        multi   = (ALUControlE == 3'd4) || (ALUControlE == 3'd5);
        expBusy = multi && cond;
        expv    = refExec(ALUControlE, srcA, srcB, refFlags);
        checkOutput("WriteDataE", WriteDataE, srcBf);
        checkOutput("BusyE", BusyE, expBusy);
        checkOutput("RegWriteOutE", RegWriteOutE, RegWriteE && cond && !expBusy);
        checkOutput("PCSrcOutE", PCSrcOutE, PCSrcE && cond && !expBusy);
        checkOutput("MemWriteOutE", MemWriteOutE, MemWriteE && cond && !expBusy);
        checkOutput("MemtoRegOutE", MemtoRegOutE, MemtoRegE);
        checkOutput("BranchTakenE", BranchTakenE, BranchE && cond);
        if (!multi) checkOutput("ALUResultE", ALUResultE, expv[31:0]);
        if (expBusy) begin
            cycles = 0;
            while (BusyE && cycles < 200) begin
                cycles++;
                @(posedge clk);
                ALUResultM = $urandom;
                ResultW    = $urandom;
                #1;
            end
            checkOutput("busyCycles", cycles, (ALUControlE == 3'd5 && srcB == 32'h0) ? 1 : WIDTH + 1);
            checkOutput("multiResult", ALUResultE, expv[31:0]);
            checkOutput("doneRegWrite", RegWriteOutE, RegWriteE);
        end
        @(negedge clk);
        #1;
        if (FlagWriteE && cond && ALUControlE != 3'd7) refFlags = expv[35:32];
        checkOutput("FlagsOut", FlagsOut, refFlags);
        @(posedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        ALUResultM = 32'h0;
        ResultW    = 32'h0;
        setIdEx(3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        #1;
        checkOutput("resetFlags", FlagsOut, 4'b0000);
        checkOutput("resetBusy", BusyE, 1'b0);
        @(posedge clk);
        rst = 1'b0;

        // Signed overflow on ADD
        setIdEx(3'd0, 4'hE, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00);
        applyStimulus();
        checkOutput("ovfFlags", FlagsOut, 4'b1001);

        // Zero result sets Z, then NE is squashed and EQ executes
        setIdEx(3'd1, 4'hE, 32'd5, 32'd5, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00);
        applyStimulus();
        setIdEx(3'd0, 4'd1, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus();
        setIdEx(3'd0, 4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus();

        // Forwarding from MEM on A, WB on store data, immediate on B
        ALUResultM = 32'h10;
        ResultW    = 32'h55;
        setIdEx(3'd0, 4'hE, 32'h99, 32'h77, 32'h4, 1'b1, 1'b0, 2'b10, 2'b01);
        applyStimulus();
        ForwardAE = 2'b11;
        applyStimulus();

        // Multi-cycle ops
        setIdEx(3'd4, 4'hE, 32'h0001_0001, 32'h3, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00);
        applyStimulus();
        setIdEx(3'd5, 4'hE, 32'hFFFF_FFFF, 32'd7, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00);
        applyStimulus();
        setIdEx(3'd5, 4'hE, 32'd9, 32'd0, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00);
        applyStimulus();

        // Reset in the middle of a multiply, then a clean multiply
        setIdEx(3'd0, 4'hE, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00);
        applyStimulus();
        setIdEx(3'd4, 4'hE, 32'h1234, 32'h777, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        #1;
        checkOutput("startBusy", BusyE, 1'b1);
        repeat (11) @(posedge clk);
        rst         = 1'b1;
        ALUControlE = 3'd0;
        #1;
        checkOutput("abortBusy", BusyE, 1'b0);
        checkOutput("abortFlags", FlagsOut, 4'b0000);
        refFlags = 4'b0000;
        @(posedge clk);
        rst = 1'b0;
        setIdEx(3'd4, 4'hE, 32'd12345, 32'd6789, 32'h0, 1'b0, 1'b1, 2'b00, 2'b00);
        applyStimulus();

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            ALUControlE = 3'($urandom_range(0, 7));
            condE       = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            rd1E        = $urandom;
            rd2E        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            ExtImmE     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            ALUResultM  = $urandom;
            ResultW     = $urandom;
            ALUSrcE     = 1'($urandom_range(0, 1));
            FlagWriteE  = 1'($urandom_range(0, 1));
            ForwardAE   = 2'($urandom_range(0, 3));
            ForwardBE   = 2'($urandom_range(0, 3));
            PCSrcE      = 1'($urandom_range(0, 1));
            RegWriteE   = 1'($urandom_range(0, 1));
            MemWriteE   = 1'($urandom_range(0, 1));
            MemtoRegE   = 1'($urandom_range(0, 1));
            BranchE     = 1'($urandom_range(0, 1));
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the RSA pipelined CPU. It consumes the ID/EX pipeline register outputs and produces the ALU result, store data and gated control for the EX/MEM register.
- Contains forwarding muxes, condition evaluation, the NZCV flags register, and a single-cycle ALU.
- Contains an iterative multi-cycle unit for MUL and MOD, needed for RSA modular exponentiation. While it runs, the unit stalls the pipeline via BusyE.

Parameters:
- WIDTH, 32, datapath width. The iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all internal state updates on the falling edge, matching the pipeline segment registers
- rst  in  1  asynchronous reset, active-high
- PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, FlagWriteE  in  1 each  control signals from the ID/EX register
- ALUControlE  in  3  operation select
- condE  in  4  ARM condition field
- rd1E, rd2E, ExtImmE  in  WIDTH  register operands and extended immediate
- ForwardAE, ForwardBE  in  2  forwarding select: 00 = rdE, 10 = ALUResultM, 01 = ResultW
- ALUResultM, ResultW  in  WIDTH  forwarded values
- ALUResultE  out  WIDTH  operation result
- WriteDataE  out  WIDTH  forwarded SrcB before the immediate mux (store data)
- PCSrcOutE, RegWriteOutE, MemWriteOutE  out  1  inputs ANDed with CondExE and with not BusyE
- MemtoRegOutE  out  1  pass-through
- BranchTakenE  out  1  BranchE AND CondExE
- FlagsOut  out  4  flags register {N,Z,C,V}
- BusyE  out  1  multi-cycle unit occupied; hazard unit holds F, D and ID/EX while high

Behaviour:
- Reset: FSM=IDLE, iteration counter=0, flags=0000, operand and result registers=0. BusyE=0. Reset asserted mid-operation aborts it immediately. Outputs are combinational from reset state and inputs.
- SrcA = mux(ForwardAE). SrcB_fwd = mux(ForwardBE). WriteDataE = SrcB_fwd. SrcB = ALUSrcE ? ExtImmE : SrcB_fwd. Select 11 treated as 00.
- CondExE decode against the flags register:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - 1110 AL = 1; 1111 = 0
- ALUControlE encoding, single-cycle ops (result same cycle):
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 ORR
  - 110 MOV (result = SrcB)
  - 111 reserved, result 0, no flag change
- ADD/SUB flags: N = msb, Z = result==0, C = carry-out (SUB carry = no borrow), V = signed overflow.
- AND/ORR/MOV flags: N and Z updated, C and V kept.
- Flags update at the edge only when FlagWriteE & CondExE & !BusyE.
- Multi-cycle ops: 100 MUL returns the low WIDTH bits of SrcA*SrcB. 101 MOD returns SrcA mod SrcB, unsigned.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if op is MUL/MOD and CondExE, BusyE=1 combinationally. At the edge, latch SrcA/SrcB and go to RUN with counter=WIDTH-1.
  - IDLE, MOD with SrcB==0: go directly to DONE with result=SrcA.
  - IDLE, condition fails: no start, BusyE=0, and the gated outputs read 0.
  - RUN: BusyE=1. Do one shift-add (MUL) or restoring-subtract (MOD) step per cycle, then decrement the counter. At counter==0, go to DONE.
  - DONE: BusyE=0, ALUResultE = result register. Flags N and Z come from the result, C and V are kept. Next edge goes to IDLE.
- Latency: MUL or MOD occupies WIDTH+2 cycles total: start, WIDTH RUN cycles, then DONE.
- Operands are latched at start, so forwarding inputs changing during RUN have no effect.
- The hazard unit guarantees ID/EX holds while BusyE=1. This block does not check it.

Decomposition:
- Shared package cpu_pkg:
  - alu_op_t enum (3 bits, values above)
  - cond_t constants
  - fwd_sel_t
  - flag bit indices N=3, Z=2, C=1, V=0
  - ex_state_t
- Natural sub-module: iter_muldiv, holding the FSM, counter, operand/result registers and BusyE.
- Condition check and ALU remain in execute_stage.

Test Plan:
- ADD 0x7FFFFFFF + 1, FlagWriteE=1, cond AL -> ALUResultE=0x80000000, FlagsOut=1001 after the edge.
- SUB 5-5 sets Z. Next op cond NE with RegWriteE=1 -> RegWriteOutE=0 and PCSrcOutE=0. Cond EQ -> RegWriteOutE=1.
- ForwardAE=10, ALUResultM=0x10, rd1E=0x99, ADD with ExtImmE=4, ALUSrcE=1 -> ALUResultE=0x14. WriteDataE equals the selected ForwardBE source.
- MUL 0x00010001 * 0x00000003 -> BusyE high 33 cycles, then DONE with ALUResultE=0x00030003. Also MOD 0xFFFFFFFF mod 7 -> 3. MOD 9 mod 0 -> DONE after 1 busy cycle, result 9.
- Reset asserted at RUN iteration 10 -> BusyE=0 immediately, FlagsOut=0000. After release, a new MUL completes correctly.
